// File: rtl/replica_pkg.sv
// ----------------------------------------------------------------------------
// replica_pkg
// Shared sizing and types for the replica ordering store and its host port.
//   city_num / city_num_log       : cities per tour and city index width
//   replica_num / replica_num_log : replicas held in the ordering RAM
//   ordering_beat_t               : 8-city host beat, byte 7 = first city
//   ordering_state_t              : host port transfer states
// ----------------------------------------------------------------------------
package replica_pkg;

    localparam int city_num        = 31;
    localparam int city_num_log    = $clog2(city_num);
    localparam int replica_num     = 32;
    localparam int replica_num_log = $clog2(replica_num);

    typedef logic [7:0][7:0] ordering_beat_t;

    typedef enum logic [1:0] {
        IDLE,
        W_UNPACK,
        R_FETCH,
        R_PRESENT
    } ordering_state_t;

endpackage

// File: rtl/ordering_beat_shifter.sv
// ----------------------------------------------------------------------------
// ordering_beat_shifter
// 64-bit byte shifter shared by the write (unpack) and read (pack) paths.
// A shift moves every byte up one position: byte 7 leaves (the head, which
// the top module reads as the next city to write) and shift_in enters at
// byte 0. A write path shift simply presents zero on shift_in.
//   clk, reset : clock, synchronous active-high clear
//   load       : replace the whole beat with load_data (priority over shift)
//   shift      : shift one byte toward byte 7, shift_in enters byte 0
//   beat       : current register contents
// ----------------------------------------------------------------------------
module ordering_beat_shifter
    import replica_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           load,
    input  ordering_beat_t load_data,
    input  logic           shift,
    input  logic [7:0]     shift_in,
    output ordering_beat_t beat
);

    always_ff @(posedge clk) begin
        if (reset) begin
            beat <= '0;
        end else if (load) begin
            beat <= load_data;
        end else if (shift) begin
            beat <= {beat[6:0], shift_in};
        end
    end

endmodule

// File: rtl/ordering_port.sv
// ----------------------------------------------------------------------------
// ordering_port
// Host-side slave of the ordering RAM. A write transfer accepts 8-city beats
// and unpacks them one city per cycle into the RAM; a read transfer fetches
// cities one per cycle and packs them 8 per beat. Each transfer covers one
// replica's tour; the replica pointer then advances, wrapping to 0.
//   clk, reset          : clock, synchronous active-high reset
//   ordering_write      : host write transfer in progress
//   ordering_wdata      : write beat, byte 7 = first city of the beat
//   ordering_read       : host read transfer in progress
//   ordering_ready      : 1-cycle pulse, write beat taken / read beat valid
//   ordering_out_valid  : 1-cycle pulse with ordering_ready on read beats
//   ordering_out_data   : read beat, byte 7 = first city, held between beats
//   run_busy            : optimiser owns the RAM, no new beat may start
//   xfer_restart        : pointer to replica 0 and abort any transfer
//   mem_we / mem_re     : RAM write / read strobes
//   mem_replica         : RAM replica address
//   mem_city            : RAM city address
//   mem_wdata           : city value written
//   mem_rdata           : RAM read data, one cycle after mem_re
// ----------------------------------------------------------------------------
module ordering_port
    import replica_pkg::*;
#(
    parameter int CITY_NUM    = city_num,
    parameter int CITY_LOG    = city_num_log,
    parameter int REPLICA_NUM = replica_num,
    parameter int REPLICA_LOG = replica_num_log
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ordering_write,
    input  logic [7:0][7:0]        ordering_wdata,
    input  logic                   ordering_read,
    output logic                   ordering_ready,
    output logic                   ordering_out_valid,
    output logic [7:0][7:0]        ordering_out_data,
    input  logic                   run_busy,
    input  logic                   xfer_restart,
    output logic                   mem_we,
    output logic                   mem_re,
    output logic [REPLICA_LOG-1:0] mem_replica,
    output logic [CITY_LOG-1:0]    mem_city,
    output logic [7:0]             mem_wdata,
    input  logic [7:0]             mem_rdata
);

    localparam logic [CITY_LOG-1:0]    CITY_LAST    = CITY_LOG'(CITY_NUM - 1);
    localparam logic [REPLICA_LOG-1:0] REPLICA_LAST = REPLICA_LOG'(REPLICA_NUM - 1);

    ordering_state_t state, state_nxt;

    logic [CITY_LOG-1:0]    city_cnt;
    logic [REPLICA_LOG-1:0] replica_ptr;
    logic [3:0]             beat_len;
    logic [3:0]             beat_len_new;
    logic [3:0]             beat_idx;
    logic                   rd_valid;
    logic                   ready_q;
    logic                   valid_q;
    ordering_beat_t         out_q;

    // FSM decode
    logic           beat_start;
    logic           write_accept;
    logic           beat_done;
    logic           abort;
    logic           we_strobe;
    logic           re_strobe;
    logic           sh_load;
    ordering_beat_t sh_load_data;
    logic           sh_shift;
    logic [7:0]     sh_in;
    ordering_beat_t sh_beat;

    logic           last_city;
    logic [2:0]     pad_bytes;
    logic [63:0]    fill_raw;
    logic [63:0]    fill_beat;

    // Cities left in the tour, capped at one beat; city_cnt never reaches
    // CITY_NUM, so this is always at least 1.
    assign beat_len_new = ((CITY_NUM - int'(city_cnt)) >= 8) ? 4'd8
                                                             : 4'(CITY_NUM - int'(city_cnt));
    assign last_city    = (city_cnt == CITY_LAST);

    // The final byte is merged straight from mem_rdata, then the beat is
    // left-aligned so the first city lands in byte 7 and the pad bytes of a
    // short beat come out as zero.
    assign pad_bytes = 3'(4'd8 - beat_len);
    assign fill_raw  = {sh_beat[6:0], mem_rdata};
    assign fill_beat = fill_raw << {pad_bytes, 3'b000};

    ordering_beat_shifter u_shifter (
        .clk       (clk),
        .reset     (reset),
        .load      (sh_load),
        .load_data (sh_load_data),
        .shift     (sh_shift),
        .shift_in  (sh_in),
        .beat      (sh_beat)
    );

    always_ff @(posedge clk) begin
        if (reset || xfer_restart) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        beat_start   = 1'b0;
        write_accept = 1'b0;
        beat_done    = 1'b0;
        abort        = 1'b0;
        we_strobe    = 1'b0;
        re_strobe    = 1'b0;
        sh_load      = 1'b0;
        sh_load_data = '0;
        sh_shift     = 1'b0;
        sh_in        = '0;

        unique case (state)
            IDLE: begin
                if (ordering_write && !run_busy) begin
                    state_nxt    = W_UNPACK;
                    beat_start   = 1'b1;
                    write_accept = 1'b1;
                    sh_load      = 1'b1;
                    sh_load_data = ordering_wdata;
                end else if (ordering_read && !run_busy) begin
                    state_nxt  = R_FETCH;
                    beat_start = 1'b1;
                    sh_load    = 1'b1;
                end else if (!ordering_write && !ordering_read && (city_cnt != '0)) begin
                    abort = 1'b1;
                end
            end
            W_UNPACK: begin
                we_strobe = 1'b1;
                sh_shift  = 1'b1;
                if (beat_idx == beat_len - 4'd1) begin
                    state_nxt = IDLE;
                end
            end
            R_FETCH: begin
                // One extra cycle after the last mem_re waits for its data.
                re_strobe = (beat_idx < beat_len);
                sh_shift  = rd_valid;
                sh_in     = mem_rdata;
                if (beat_idx == beat_len) begin
                    state_nxt = R_PRESENT;
                    beat_done = 1'b1;
                end
            end
            R_PRESENT: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            city_cnt    <= '0;
            replica_ptr <= '0;
            beat_idx    <= '0;
            beat_len    <= '0;
            rd_valid    <= 1'b0;
            ready_q     <= 1'b0;
            valid_q     <= 1'b0;
            out_q       <= '0;
        end else if (xfer_restart) begin
            city_cnt    <= '0;
            replica_ptr <= '0;
            beat_idx    <= '0;
            rd_valid    <= 1'b0;
            ready_q     <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            ready_q  <= write_accept | beat_done;
            valid_q  <= beat_done;
            rd_valid <= re_strobe;

            if (beat_start) begin
                beat_idx <= '0;
                beat_len <= beat_len_new;
            end else if (we_strobe || re_strobe) begin
                beat_idx <= beat_idx + 4'd1;
            end

            if (we_strobe || re_strobe) begin
                if (last_city) begin
                    city_cnt    <= '0;
                    replica_ptr <= (replica_ptr == REPLICA_LAST) ? '0
                                                                 : replica_ptr + REPLICA_LOG'(1);
                end else begin
                    city_cnt <= city_cnt + CITY_LOG'(1);
                end
            end else if (abort) begin
                city_cnt <= '0;
            end

            if (beat_done) begin
                out_q <= fill_beat;
            end
        end
    end

    assign ordering_ready     = ready_q;
    assign ordering_out_valid = valid_q;
    assign ordering_out_data  = out_q;
    assign mem_we             = we_strobe;
    assign mem_re             = re_strobe;
    assign mem_replica        = replica_ptr;
    assign mem_city           = city_cnt;
    assign mem_wdata          = we_strobe ? sh_beat[7] : '0;

endmodule

// File: tb/tb_ordering_port.sv
module tb_ordering_port;

    logic            clk = 1'b0;
    logic            reset;
    logic            ordering_write;
    logic [7:0][7:0] ordering_wdata;
    logic            ordering_read;
    logic            ordering_ready;
    logic            ordering_out_valid;
    logic [7:0][7:0] ordering_out_data;
    logic            run_busy;
    logic            xfer_restart;
    logic            mem_we;
    logic            mem_re;
    logic [4:0]      mem_replica;
    logic [4:0]      mem_city;
    logic [7:0]      mem_wdata;
    logic [7:0]      mem_rdata;

    int total = 0;
    int bad   = 0;

    int we_cnt       = 0;
    int re_cnt       = 0;
    int rdy_cnt      = 0;
    int both_cnt     = 0;
    int addr_err_cnt = 0;

    logic [7:0]      ram [0:31][0:31];
    logic [7:0]      rdq;
    logic [7:0][7:0] rd_beats [0:3];
    int              rd_lat;

    always #5 clk = ~clk;

    ordering_port #(
        .CITY_NUM    (31),
        .CITY_LOG    (5),
        .REPLICA_NUM (32),
        .REPLICA_LOG (5)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .ordering_write     (ordering_write),
        .ordering_wdata     (ordering_wdata),
        .ordering_read      (ordering_read),
        .ordering_ready     (ordering_ready),
        .ordering_out_valid (ordering_out_valid),
        .ordering_out_data  (ordering_out_data),
        .run_busy           (run_busy),
        .xfer_restart       (xfer_restart),
        .mem_we             (mem_we),
        .mem_re             (mem_re),
        .mem_replica        (mem_replica),
        .mem_city           (mem_city),
        .mem_wdata          (mem_wdata),
        .mem_rdata          (mem_rdata)
    );

    // RAM model: synchronous write, read data one cycle after mem_re
    always @(posedge clk) begin
        if (mem_we) ram[mem_replica][mem_city] <= mem_wdata;
        if (mem_re) rdq <= ram[mem_replica][mem_city];
    end
    assign mem_rdata = rdq;

    always @(negedge clk) begin
        if (mem_we) we_cnt++;
        if (mem_re) re_cnt++;
        if (ordering_ready) rdy_cnt++;
        if (mem_we && mem_re) both_cnt++;
        if ((mem_we || mem_re) && (mem_city > 5'd30)) addr_err_cnt++;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [7:0] val(input int t, input int k);
        return 8'((k + t * 37) & 255);
    endfunction

    task automatic wait_ready(input int limit, output int cyc);
        cyc = -1;
        for (int i = 1; i <= limit; i++) begin
            if (cyc < 0) begin
                tick();
                if (ordering_ready) cyc = i;
            end
        end
    endtask

    task automatic pulse_restart();
        xfer_restart = 1'b1;
        tick();
        xfer_restart = 1'b0;
        tick();
    endtask

    task automatic write_tour(input int t, input bit drop_after);
        int cyc;
        for (int b = 0; b < 4; b++) begin
            for (int j = 0; j < 8; j++)
                ordering_wdata[7-j] = (b * 8 + j < 31) ? val(t, b * 8 + j) : 8'h00;
            ordering_write = 1'b1;
            wait_ready(40, cyc);
            total++;
            if (cyc < 0) begin
                bad++;
                $display("FAIL write_ready tour=%0d beat=%0d got=timeout want=pulse", t, b);
            end
        end
        if (drop_after) ordering_write = 1'b0;
    endtask

    task automatic read_beats(input int nb);
        int cyc;
        ordering_read = 1'b1;
        for (int b = 0; b < nb; b++) begin
            wait_ready(40, cyc);
            if (b == 0) rd_lat = cyc;
            total++;
            if (cyc < 0) begin
                bad++;
                $display("FAIL read_ready beat=%0d got=timeout want=pulse", b);
            end else begin
                rd_beats[b] = ordering_out_data;
                total++;
                if (ordering_out_valid !== 1'b1) begin
                    bad++;
                    $display("FAIL read_valid beat=%0d got=%b want=1", b, ordering_out_valid);
                end
            end
        end
        ordering_read = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        total++;
        if ({ordering_ready, ordering_out_valid, mem_we, mem_re} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_strobes got=%b want=0000",
                     {ordering_ready, ordering_out_valid, mem_we, mem_re});
        end
        total++;
        if (ordering_out_data !== 64'h0) begin
            bad++;
            $display("FAIL reset_out_data got=%h want=0", ordering_out_data);
        end
        total++;
        if ({mem_replica, mem_city, mem_wdata} !== 18'h0) begin
            bad++;
            $display("FAIL reset_mem_bus got=%h/%h/%h want=0/0/0", mem_replica, mem_city, mem_wdata);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_write_tour();
        int we0, rdy0;
        pulse_restart();
        we0  = we_cnt;
        rdy0 = rdy_cnt;
        write_tour(0, 1'b1);
        repeat (12) tick();
        total++;
        if (we_cnt - we0 !== 31) begin
            bad++;
            $display("FAIL wr_we_count got=%0d want=31", we_cnt - we0);
        end
        total++;
        if (rdy_cnt - rdy0 !== 4) begin
            bad++;
            $display("FAIL wr_ready_count got=%0d want=4", rdy_cnt - rdy0);
        end
        for (int k = 0; k < 31; k++) begin
            total++;
            if (ram[0][k] !== 8'(k)) begin
                bad++;
                $display("FAIL wr_ram city=%0d got=%h want=%h", k, ram[0][k], 8'(k));
            end
        end
        total++;
        if (mem_replica !== 5'd1) begin
            bad++;
            $display("FAIL wr_replica_ptr got=%0d want=1", mem_replica);
        end
    endtask

    task automatic test_read_tour();
        logic [63:0] exp_beats [0:3];
        int re0;
        exp_beats[0] = 64'h0001020304050607;
        exp_beats[1] = 64'h08090A0B0C0D0E0F;
        exp_beats[2] = 64'h1011121314151617;
        exp_beats[3] = 64'h18191A1B1C1D1E00;
        pulse_restart();
        re0 = re_cnt;
        read_beats(4);
        repeat (3) tick();
        for (int i = 0; i < 4; i++) begin
            total++;
            if (rd_beats[i] !== exp_beats[i]) begin
                bad++;
                $display("FAIL rd_beat%0d got=%h want=%h", i, rd_beats[i], exp_beats[i]);
            end
        end
        total++;
        if (rd_lat !== 10) begin
            bad++;
            $display("FAIL rd_latency got=%0d want=10", rd_lat);
        end
        total++;
        if (re_cnt - re0 !== 31) begin
            bad++;
            $display("FAIL rd_re_count got=%0d want=31", re_cnt - re0);
        end
        total++;
        if (rd_beats[3][0] !== 8'h00) begin
            bad++;
            $display("FAIL rd_pad_byte got=%h want=00", rd_beats[3][0]);
        end
        total++;
        if (mem_replica !== 5'd1) begin
            bad++;
            $display("FAIL rd_replica_ptr got=%0d want=1", mem_replica);
        end
    endtask

    task automatic test_back_to_back();
        pulse_restart();
        for (int t = 0; t < 33; t++) write_tour(t, t == 32);
        repeat (12) tick();
        for (int k = 0; k < 31; k++) begin
            total++;
            if (ram[0][k] !== 8'(k + 8'hA0)) begin
                bad++;
                $display("FAIL b2b_rep0 city=%0d got=%h want=%h", k, ram[0][k], 8'(k + 8'hA0));
            end
            total++;
            if (ram[31][k] !== 8'(k + 8'h7B)) begin
                bad++;
                $display("FAIL b2b_rep31 city=%0d got=%h want=%h", k, ram[31][k], 8'(k + 8'h7B));
            end
            total++;
            if (ram[1][k] !== 8'(k + 8'h25)) begin
                bad++;
                $display("FAIL b2b_rep1 city=%0d got=%h want=%h", k, ram[1][k], 8'(k + 8'h25));
            end
        end
        total++;
        if (mem_replica !== 5'd1) begin
            bad++;
            $display("FAIL b2b_replica_ptr got=%0d want=1", mem_replica);
        end
    endtask

    task automatic test_read_abort();
        pulse_restart();
        read_beats(2);
        repeat (4) tick();
        total++;
        if (rd_beats[1] !== 64'hA8A9AAABACADAEAF) begin
            bad++;
            $display("FAIL abort_beat1 got=%h want=a8a9aaabacadaeaf", rd_beats[1]);
        end
        total++;
        if ({mem_replica, mem_city} !== 10'h0) begin
            bad++;
            $display("FAIL abort_ptrs got=%0d/%0d want=0/0", mem_replica, mem_city);
        end
        read_beats(1);
        repeat (4) tick();
        total++;
        if (rd_beats[0] !== 64'hA0A1A2A3A4A5A6A7) begin
            bad++;
            $display("FAIL abort_reread got=%h want=a0a1a2a3a4a5a6a7", rd_beats[0]);
        end
    endtask

    task automatic test_run_busy();
        int we0, rdy0, cyc;
        pulse_restart();
        run_busy       = 1'b1;
        ordering_wdata = 64'h1122334455667788;
        ordering_write = 1'b1;
        we0  = we_cnt;
        rdy0 = rdy_cnt;
        repeat (50) tick();
        total++;
        if (rdy_cnt - rdy0 !== 0 || we_cnt - we0 !== 0) begin
            bad++;
            $display("FAIL busy_block got=ready%0d/we%0d want=0/0", rdy_cnt - rdy0, we_cnt - we0);
        end
        run_busy = 1'b0;
        wait_ready(5, cyc);
        total++;
        if (cyc !== 1) begin
            bad++;
            $display("FAIL busy_release_latency got=%0d want=1", cyc);
        end
        // busy raised mid-unpack must not stall it
        run_busy       = 1'b1;
        ordering_write = 1'b0;
        repeat (12) tick();
        total++;
        if (we_cnt - we0 !== 8) begin
            bad++;
            $display("FAIL busy_unpack_we got=%0d want=8", we_cnt - we0);
        end
        total++;
        if (ram[0][0] !== 8'h11 || ram[0][7] !== 8'h88) begin
            bad++;
            $display("FAIL busy_ram got=%h/%h want=11/88", ram[0][0], ram[0][7]);
        end
        run_busy = 1'b0;
        tick();
    endtask

    task automatic test_both();
        int we0, re0, cyc;
        pulse_restart();
        ordering_wdata = 64'hC1C2C3C4C5C6C7C8;
        ordering_write = 1'b1;
        ordering_read  = 1'b1;
        we0 = we_cnt;
        re0 = re_cnt;
        wait_ready(5, cyc);
        ordering_write = 1'b0;
        ordering_read  = 1'b0;
        total++;
        if (cyc !== 1) begin
            bad++;
            $display("FAIL both_ready_latency got=%0d want=1", cyc);
        end
        repeat (12) tick();
        total++;
        if (re_cnt - re0 !== 0) begin
            bad++;
            $display("FAIL both_no_re got=%0d want=0", re_cnt - re0);
        end
        total++;
        if (we_cnt - we0 !== 8) begin
            bad++;
            $display("FAIL both_we got=%0d want=8", we_cnt - we0);
        end
        total++;
        if (ram[0][0] !== 8'hC1 || ram[0][7] !== 8'hC8) begin
            bad++;
            $display("FAIL both_ram got=%h/%h want=c1/c8", ram[0][0], ram[0][7]);
        end
        total++;
        if (ordering_out_data !== 64'hA0A1A2A3A4A5A6A7) begin
            bad++;
            $display("FAIL out_data_held got=%h want=a0a1a2a3a4a5a6a7", ordering_out_data);
        end
    endtask

    task automatic test_restart_mid();
        int rdy0, re0;
        pulse_restart();
        ordering_read = 1'b1;
        repeat (4) tick();
        xfer_restart  = 1'b1;
        ordering_read = 1'b0;
        tick();
        xfer_restart = 1'b0;
        rdy0 = rdy_cnt;
        re0  = re_cnt;
        repeat (15) tick();
        total++;
        if (rdy_cnt - rdy0 !== 0) begin
            bad++;
            $display("FAIL restart_no_ready got=%0d want=0", rdy_cnt - rdy0);
        end
        total++;
        if (re_cnt - re0 !== 0) begin
            bad++;
            $display("FAIL restart_no_re got=%0d want=0", re_cnt - re0);
        end
        total++;
        if ({mem_replica, mem_city} !== 10'h0) begin
            bad++;
            $display("FAIL restart_ptrs got=%0d/%0d want=0/0", mem_replica, mem_city);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        pulse_restart();
        ordering_wdata = 64'h0102030405060708;
        ordering_write = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (!seen) begin
                tick();
                seen = mem_we;
            end
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL resetmid_start got=no_we want=we");
        end
        tick();
        reset          = 1'b1;
        ordering_write = 1'b0;
        tick();
        total++;
        if (mem_we !== 1'b0 || ordering_ready !== 1'b0) begin
            bad++;
            $display("FAIL resetmid_we got=%b/%b want=0/0", mem_we, ordering_ready);
        end
        total++;
        if (mem_city !== 5'd0) begin
            bad++;
            $display("FAIL resetmid_city got=%0d want=0", mem_city);
        end
        reset = 1'b0;
        tick();
        tick();
        total++;
        if (mem_we !== 1'b0) begin
            bad++;
            $display("FAIL resetmid_after got=%b want=0", mem_we);
        end
    endtask

    initial begin
        reset          = 1'b1;
        ordering_write = 1'b0;
        ordering_wdata = '0;
        ordering_read  = 1'b0;
        run_busy       = 1'b0;
        xfer_restart   = 1'b0;

        test_reset();
        test_write_tour();
        test_read_tour();
        test_back_to_back();
        test_read_abort();
        test_run_busy();
        test_both();
        test_restart_mid();
        test_reset_mid();

        total++;
        if (both_cnt !== 0) begin
            bad++;
            $display("FAIL we_and_re got=%0d want=0", both_cnt);
        end
        total++;
        if (addr_err_cnt !== 0) begin
            bad++;
            $display("FAIL city_range got=%0d want=0", addr_err_cnt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
